// File: rtl/ddr4_dqsw_wrlvl_ctrl.sv
// DDR4 DQSW write-leveling search: sweeps the DQSW delay line tap by tap and reports the
// first tap where majority-voted DQ feedback rises after having been seen low.
module ddr4_dqsw_wrlvl_ctrl #(
    parameter int unsigned TAP_W         = 8,
    parameter int unsigned MAX_TAPS      = 128,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned FB_LAT        = 6,
    parameter int unsigned SAMPLE_COUNT  = 4
) (
    input  logic             FAB_CLK,
    input  logic             ARST,
    input  logic             START,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [TAP_W-1:0] TAP_RESULT,
    output logic             DELAY_LINE_LOAD,
    output logic             DELAY_LINE_MOVE,
    output logic             DELAY_LINE_DIRECTION,
    input  logic             DELAY_LINE_OUT_OF_RANGE,
    output logic             EYE_MONITOR_CLEAR_FLAGS,
    output logic [1:0]       TX_DATA,
    output logic [1:0]       OE_DATA,
    input  logic [1:0]       RX_DATA
);

    localparam int unsigned CNT_MAX = (SETTLE_CYCLES > FB_LAT) ? SETTLE_CYCLES : FB_LAT;
    localparam int unsigned CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);
    localparam int unsigned SMP_W   = $clog2(SAMPLE_COUNT + 1);

    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(FB_LAT - 1);
    localparam logic [SMP_W-1:0] SMP_LAST    = SMP_W'(SAMPLE_COUNT - 1);
    localparam logic [SMP_W:0]   SMP_TOTAL   = (SMP_W + 1)'(SAMPLE_COUNT);
    localparam logic [TAP_W-1:0] TAP_LAST    = TAP_W'(MAX_TAPS - 1);

    typedef enum logic [3:0] {
        StIdle, StLoad, StSettle, StPulse, StWait, StSample, StDecide, StMove, StDone, StFail
    } state_e;

    state_e             state_q, state_d;
    logic [TAP_W-1:0]   tap_q, tap_d, tap_result_q, tap_result_d;
    logic               seen_zero_q, seen_zero_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SMP_W-1:0]   samples_q, samples_d, ones_q, ones_d;
    logic               busy_d, done_d, err_d, load_d, move_d, clr_d;
    logic [1:0]         tx_d, oe_d;
    logic               vote;
    logic               unused_rx;

    assign unused_rx = RX_DATA[1];
    // Strict majority; a tie reads as 0.
    assign vote = {ones_q, 1'b0} > SMP_TOTAL;

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) state_q <= StIdle;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d      = state_q;
        tap_d        = tap_q;
        tap_result_d = tap_result_q;
        seen_zero_d  = seen_zero_q;
        cnt_d        = cnt_q;
        samples_d    = samples_q;
        ones_d       = ones_q;
        unique case (state_q)
            StIdle, StDone, StFail: begin
                if (START) begin
                    state_d     = StLoad;
                    tap_d       = '0;
                    seen_zero_d = 1'b0;
                end
            end
            StLoad: begin
                state_d = StSettle;
                cnt_d   = '0;
            end
            StSettle: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d   = StPulse;
                    cnt_d     = '0;
                    samples_d = '0;
                    ones_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StPulse: begin
                state_d = StWait;
                cnt_d   = '0;
            end
            StWait: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d = StSample;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StSample: begin
                ones_d    = ones_q + SMP_W'(RX_DATA[0]);
                samples_d = samples_q + 1'b1;
                state_d   = (samples_q == SMP_LAST) ? StDecide : StPulse;
            end
            StDecide: begin
                if (vote && seen_zero_q) begin
                    state_d      = StDone;
                    tap_result_d = tap_q;
                end else begin
                    if (!vote) seen_zero_d = 1'b1;
                    if (tap_q == TAP_LAST || DELAY_LINE_OUT_OF_RANGE) begin
                        state_d      = StFail;
                        tap_result_d = tap_q;
                    end else begin
                        state_d = StMove;
                    end
                end
            end
            StMove: begin
                tap_d   = tap_q + 1'b1;
                state_d = StSettle;
                cnt_d   = '0;
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are decoded from the next state so every output is a plain flop.
    always_comb begin
        busy_d = 1'b1;
        done_d = 1'b0;
        err_d  = 1'b0;
        load_d = 1'b0;
        move_d = 1'b0;
        clr_d  = 1'b0;
        tx_d   = 2'b00;
        oe_d   = 2'b00;
        unique case (state_d)
            StIdle:  busy_d = 1'b0;
            StDone:  begin busy_d = 1'b0; done_d = 1'b1; end
            StFail:  begin busy_d = 1'b0; err_d  = 1'b1; end
            StLoad:  begin load_d = 1'b1; clr_d  = 1'b1; end
            StMove:  move_d = 1'b1;
            StPulse: begin tx_d = 2'b01; oe_d = 2'b11; end
            default: ;
        endcase
    end

    always_ff @(posedge FAB_CLK or posedge ARST) begin
        if (ARST) begin
            tap_q                   <= '0;
            tap_result_q            <= '0;
            seen_zero_q             <= 1'b0;
            cnt_q                   <= '0;
            samples_q               <= '0;
            ones_q                  <= '0;
            BUSY                    <= 1'b0;
            DONE                    <= 1'b0;
            ERR                     <= 1'b0;
            DELAY_LINE_LOAD         <= 1'b0;
            DELAY_LINE_MOVE         <= 1'b0;
            DELAY_LINE_DIRECTION    <= 1'b0;
            EYE_MONITOR_CLEAR_FLAGS <= 1'b0;
            TX_DATA                 <= 2'b00;
            OE_DATA                 <= 2'b00;
        end else begin
            tap_q                   <= tap_d;
            tap_result_q            <= tap_result_d;
            seen_zero_q             <= seen_zero_d;
            cnt_q                   <= cnt_d;
            samples_q               <= samples_d;
            ones_q                  <= ones_d;
            BUSY                    <= busy_d;
            DONE                    <= done_d;
            ERR                     <= err_d;
            DELAY_LINE_LOAD         <= load_d;
            DELAY_LINE_MOVE         <= move_d;
            DELAY_LINE_DIRECTION    <= busy_d;
            EYE_MONITOR_CLEAR_FLAGS <= clr_d;
            TX_DATA                 <= tx_d;
            OE_DATA                 <= oe_d;
        end
    end

    assign TAP_RESULT = tap_result_q;

endmodule

// File: tb/tb_ddr4_dqsw_wrlvl_ctrl.sv
// Directed bench for ddr4_dqsw_wrlvl_ctrl: a delay-line/feedback model drives the DUT and a
// scoreboard queue holds the expected outcome of each search launched.
module tb_ddr4_dqsw_wrlvl_ctrl;

    localparam int LAT   = 8 + 4 * (6 + 2) + 2;
    localparam int LIMIT = 20000;

    logic       FAB_CLK = 1'b0;
    logic       ARST    = 1'b1;
    logic       START   = 1'b0;
    logic       BUSY, DONE, ERR;
    logic [7:0] TAP_RESULT;
    logic       DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION;
    logic       DELAY_LINE_OUT_OF_RANGE = 1'b0;
    logic       EYE_MONITOR_CLEAR_FLAGS;
    logic [1:0] TX_DATA, OE_DATA;
    logic [1:0] RX_DATA = 2'b00;

    ddr4_dqsw_wrlvl_ctrl dut (
        .FAB_CLK                 (FAB_CLK),
        .ARST                    (ARST),
        .START                   (START),
        .BUSY                    (BUSY),
        .DONE                    (DONE),
        .ERR                     (ERR),
        .TAP_RESULT              (TAP_RESULT),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE),
        .EYE_MONITOR_CLEAR_FLAGS (EYE_MONITOR_CLEAR_FLAGS),
        .TX_DATA                 (TX_DATA),
        .OE_DATA                 (OE_DATA),
        .RX_DATA                 (RX_DATA)
    );

    always #5 FAB_CLK = ~FAB_CLK;

    typedef struct {
        logic      done;
        logic      err;
        logic [7:0] tap;
        int        moves;
        int        loads;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   scen     = 0;
    int   tap_m    = 0;
    int   pidx     = 0;
    int   move_cnt = 0;
    int   load_cnt = 0;
    int   prot_err = 0;
    int   cyc      = 0;
    int   last_pulse = 0;

    function automatic logic fb(input int s, input int t, input int p);
        case (s)
            0:       return (t < 5) ? 1'b1 : (t < 20) ? 1'b0 : 1'b1;
            2:       return (t < 10) ? 1'b0 : (t == 10) ? (p != 3) : 1'b1;
            3:       return (t < 10) ? 1'b0 : (t == 10) ? (p % 2 == 0) : 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Delay-line / IOD model plus protocol monitor.
    always @(negedge FAB_CLK) begin
        cyc = cyc + 1;
        if (DELAY_LINE_LOAD) begin
            tap_m = 0; pidx = 0; load_cnt = load_cnt + 1; last_pulse = cyc;
        end
        if (DELAY_LINE_MOVE) begin
            if (cyc - last_pulse != LAT || !BUSY) prot_err = prot_err + 1;
            tap_m = tap_m + 1; pidx = 0; move_cnt = move_cnt + 1; last_pulse = cyc;
        end
        if (TX_DATA == 2'b01) begin
            RX_DATA = {1'b0, fb(scen, tap_m, pidx)};
            pidx = pidx + 1;
        end
        if (!((TX_DATA == 2'b00 && OE_DATA == 2'b00) || (TX_DATA == 2'b01 && OE_DATA == 2'b11)))
            prot_err = prot_err + 1;
        if (DELAY_LINE_DIRECTION !== BUSY) prot_err = prot_err + 1;
        if (EYE_MONITOR_CLEAR_FLAGS !== DELAY_LINE_LOAD) prot_err = prot_err + 1;
        DELAY_LINE_OUT_OF_RANGE = (scen == 4 && tap_m >= 30);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic launch(input int s, input logic d, input logic e, input int t, input int m);
        exp_t x;
        @(negedge FAB_CLK);
        scen = s; move_cnt = 0; load_cnt = 0;
        x.done = d; x.err = e; x.tap = 8'(t); x.moves = m; x.loads = 1;
        exp_q.push_back(x);
        START = 1'b1;
        @(negedge FAB_CLK);
        START = 1'b0;
    endtask

    task automatic finish_search(input string tag);
        exp_t x;
        int n = 0;
        while (!(DONE || ERR) && n < LIMIT) begin
            @(negedge FAB_CLK);
            n++;
        end
        chk({tag, "_timeout"}, 32'(n < LIMIT), 32'd1);
        x = exp_q.pop_front();
        chk({tag, "_done"}, 32'(DONE), 32'(x.done));
        chk({tag, "_err"},  32'(ERR),  32'(x.err));
        chk({tag, "_busy"}, 32'(BUSY), 32'd0);
        chk({tag, "_tap"},  32'(TAP_RESULT), 32'(x.tap));
        repeat (5) @(negedge FAB_CLK);
        chk({tag, "_moves"}, 32'(move_cnt), 32'(x.moves));
        chk({tag, "_loads"}, 32'(load_cnt), 32'(x.loads));
        chk({tag, "_held"},  32'({DONE, ERR}), 32'({x.done, x.err}));
        chk({tag, "_prot"},  32'(prot_err), 32'd0);
    endtask

    initial begin
        int n;
        #12;
        chk("reset_outs", 32'({BUSY, DONE, ERR, TAP_RESULT, DELAY_LINE_LOAD, DELAY_LINE_MOVE,
                               DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS, TX_DATA, OE_DATA}),
            32'd0);
        @(negedge FAB_CLK);
        ARST = 1'b0;
        repeat (3) @(negedge FAB_CLK);
        chk("release_no_pulse", 32'(load_cnt + move_cnt), 32'd0);

        // Main sweep with a stray START mid-search.
        launch(0, 1'b1, 1'b0, 20, 20);
        n = 0;
        while (tap_m < 5 && n < LIMIT) begin @(negedge FAB_CLK); n++; end
        START = 1'b1;
        @(negedge FAB_CLK);
        START = 1'b0;
        chk("busy_mid", 32'(BUSY), 32'd1);
        finish_search("sweep");

        // Restart from DONE: DONE clears right away.
        launch(2, 1'b1, 1'b0, 10, 10);
        chk("restart_done_clr", 32'({DONE, BUSY}), 32'b01);
        finish_search("maj3of4");

        launch(3, 1'b1, 1'b0, 11, 11);
        finish_search("tie");

        launch(1, 1'b0, 1'b1, 127, 127);
        finish_search("allzero");

        launch(4, 1'b0, 1'b1, 30, 30);
        finish_search("oor");

        // Abort during WAIT at tap 7.
        launch(1, 1'b0, 1'b1, 127, 127);
        n = 0;
        while (!(tap_m == 7 && TX_DATA == 2'b01) && n < LIMIT) begin @(negedge FAB_CLK); n++; end
        chk("abort_reach", 32'(n < LIMIT), 32'd1);
        repeat (2) @(negedge FAB_CLK);
        #1 ARST = 1'b1;
        #1;
        chk("abort_outs", 32'({BUSY, DONE, ERR, TAP_RESULT, DELAY_LINE_LOAD, DELAY_LINE_MOVE,
                               DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS, TX_DATA, OE_DATA}),
            32'd0);
        void'(exp_q.pop_front());
        @(negedge FAB_CLK);
        ARST = 1'b0;
        n = load_cnt + move_cnt;
        repeat (3) @(negedge FAB_CLK);
        chk("abort_idle", 32'(load_cnt + move_cnt - n), 32'd0);
        chk("abort_busy", 32'(BUSY), 32'd0);
        launch(0, 1'b1, 1'b0, 20, 20);
        finish_search("after_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
